mwb_mem_ctrl: RTL and testbench

Memory/write-back stage controller for the three-stage RV32I pipeline. Sits behind the EX/MWB pipeline register and decodes the held instruction (IR, ALU result, store data). It runs a req/ack handshake to data memory for loads and stores, freezing the upstream stages while an access is outstanding. It drives the single register-file write port for every retiring instruction.

---
 rtl/rv32_pkg.sv | 53 +++++
 rtl/mwb_mem_ctrl_if.sv | 15 +
 rtl/mwb_load_align.sv | 22 ++
 rtl/mwb_mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mwb_mem_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the MWB stage: opcodes, load/store funct3 codes,
// stage state encoding and byte-lane helpers.
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} mwb_state_e;

  // Access held stable on the memory bus while a request is outstanding.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [4:0]  rd;
  } mem_acc_t;

  // sz is funct3[1:0]: 0 byte, 1 half, 2 word.
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mwb_mem_ctrl_if.sv
// Data-memory req/ack bus between the MWB controller and the data memory.
interface mwb_mem_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  input  dmem_ack, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mwb_load_align.sv
// Picks the addressed byte/half out of a read word and sign/zero extends it.
module mwb_load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_val
);
  logic [31:0] sh;

  always_comb begin
    sh = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    load_val = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   load_val = {24'b0, sh[7:0]};
      F3_H:    load_val = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   load_val = {16'b0, sh[15:0]};
      default: load_val = rdata;
    endcase
  end
endmodule

// File: rtl/mwb_mem_ctrl.sv
// Memory/write-back stage: runs the dmem req/ack handshake for loads/stores,
// stalls upstream while an access is in flight, and drives the RF write port.
module mwb_mem_ctrl
  import rv32_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mwb_valid,
  input  logic [31:0]        mwb_ir,
  input  logic [31:0]        mwb_alu_out,
  input  logic [31:0]        mwb_rs2,
  mwb_mem_ctrl_if.master     dmem,
  output logic               pipe_stall,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic               misalign,
  output logic               err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  mwb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  mem_acc_t      acc_q, acc_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          misalign_q, misalign_d;
  logic          err_q, err_d;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic        is_mem, is_wb, aligned, issue, timeout_hit;
  logic [31:0] load_val;
  logic        unused_ir;

  assign opcode    = mwb_ir[6:0];
  assign rd        = mwb_ir[11:7];
  assign f3        = mwb_ir[14:12];
  assign unused_ir = ^mwb_ir[31:15];

  // Loads/stores with a reserved funct3 fall through as no-ops.
  assign is_mem = (opcode == OPC_LOAD  && f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) ||
                  (opcode == OPC_STORE && f3 inside {F3_B, F3_H, F3_W});
  assign is_wb  = (opcode inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR}) &&
                  (rd != 5'd0);

  always_comb begin
    case (f3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~mwb_alu_out[0];
      default: aligned = (mwb_alu_out[1:0] == 2'b00);
    endcase
  end

  assign issue       = (state_q == IDLE) && mwb_valid && is_mem && aligned;
  assign timeout_hit = (state_q == REQ) && (cnt_q == CW'(TIMEOUT - 1));
  assign pipe_stall  = issue || ((state_q == REQ) && !dmem.dmem_ack && !timeout_hit);

  mwb_load_align u_align (
    .rdata    (dmem.dmem_rdata),
    .addr_lo  (acc_q.lo),
    .funct3   (acc_q.f3),
    .load_val (load_val)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    acc_d      = acc_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    misalign_d = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d     = REQ;
          cnt_d       = '0;
          req_d       = 1'b1;
          acc_d.we    = (opcode == OPC_STORE);
          acc_d.addr  = {mwb_alu_out[31:2], 2'b00};
          acc_d.lo    = mwb_alu_out[1:0];
          acc_d.be    = byte_en(f3[1:0], mwb_alu_out[1:0]);
          acc_d.wdata = lane_rep(f3[1:0], mwb_rs2);
          acc_d.f3    = f3;
          acc_d.rd    = rd;
        end else if (mwb_valid && is_mem) begin
          misalign_d = 1'b1;
        end else if (mwb_valid && is_wb) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = rd;
          rf_wdata_d = mwb_alu_out;
        end
      end
      REQ: begin
        // Ack beats a same-cycle timeout.
        if (dmem.dmem_ack) begin
          state_d  = IDLE;
          req_d    = 1'b0;
          acc_d.we = 1'b0;
          if (!acc_q.we && acc_q.rd != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = acc_q.rd;
            rf_wdata_d = load_val;
          end
        end else if (timeout_hit) begin
          state_d  = IDLE;
          req_d    = 1'b0;
          acc_d.we = 1'b0;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      acc_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      acc_q      <= acc_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = acc_q.we;
  assign dmem.dmem_addr  = acc_q.addr;
  assign dmem.dmem_be    = acc_q.be;
  assign dmem.dmem_wdata = acc_q.wdata;
  assign rf_we           = rf_we_q;
  assign rf_waddr        = rf_waddr_q;
  assign rf_wdata        = rf_wdata_q;
  assign misalign        = misalign_q;
  assign err             = err_q;
endmodule

// File: tb/tb_mwb_mem_ctrl.sv
// Self-checking bench for mwb_mem_ctrl: directed cases plus randomized ALU and
// memory traffic against a byte-lane arithmetic reference model.
module tb_mwb_mem_ctrl;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        mwb_valid;
  logic [31:0] mwb_ir, mwb_alu_out, mwb_rs2;
  logic        pipe_stall, rf_we, misalign, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  int          total = 0;
  int          bad = 0;

  mwb_mem_ctrl_if bus();

  mwb_mem_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .mwb_valid(mwb_valid), .mwb_ir(mwb_ir),
    .mwb_alu_out(mwb_alu_out), .mwb_rs2(mwb_rs2), .dmem(bus),
    .pipe_stall(pipe_stall), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .misalign(misalign), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] lo);
    int mask = ((1 << m_size(f3)) - 1) << lo;
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int sz = m_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd);
    int sz = m_size(f3);
    longint v = {32'b0, rd};
    longint lim = longint'(1) << (8 * sz);
    v = (v >> (8 * int'(lo))) & (lim - 1);
    if (!f3[2] && sz < 4 && v >= (lim >> 1)) v = v - lim;
    return 32'(v);
  endfunction

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    logic [31:0] r;
    r = $urandom;
    r[6:0] = op; r[11:7] = rd; r[14:12] = f3;
    return r;
  endfunction

  // One load/store from issue through the writeback cycle; wait_n = REQ cycles without ack.
  task automatic mem_op(input bit st, input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] rdata, input int wait_n, input string tag,
                        output int stalls, output int reqs);
    logic [3:0]  ebe = m_be(f3, addr[1:0]);
    logic [31:0] ewd = m_wdata(f3, rs2);
    logic [31:0] eaddr = {addr[31:2], 2'b00};
    bit          ewr = !st && rd != 5'd0;
    stalls = 0; reqs = 0;
    @(negedge clk);
    mwb_valid = 1'b1; mwb_ir = mk_ir(st ? ST : LD, f3, rd); mwb_alu_out = addr; mwb_rs2 = rs2;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = $urandom;
    #1;
    if (pipe_stall === 1'b1) stalls++;
    total++; if (pipe_stall !== 1'b1) begin bad++; $display("FAIL %s issue_stall got=%b exp=1", tag, pipe_stall); end
    for (int k = 0; k <= wait_n; k++) begin
      @(negedge clk);
      if (bus.dmem_req === 1'b1) reqs++;
      total++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== st) begin bad++; $display("FAIL %s req/we cyc%0d got=%b%b exp=1%b", tag, k, bus.dmem_req, bus.dmem_we, st); end
      total++; if (bus.dmem_addr !== eaddr || bus.dmem_be !== ebe) begin bad++; $display("FAIL %s addr/be got=%h/%h exp=%h/%h", tag, bus.dmem_addr, bus.dmem_be, eaddr, ebe); end
      if (st) begin
        total++; if (bus.dmem_wdata !== ewd) begin bad++; $display("FAIL %s wdata got=%h exp=%h", tag, bus.dmem_wdata, ewd); end
      end
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL %s rf_we_in_req got=%b exp=0", tag, rf_we); end
      bus.dmem_ack = (k == wait_n);
      bus.dmem_rdata = (k == wait_n) ? rdata : $urandom;
      #1;
      if (pipe_stall === 1'b1) stalls++;
      total++; if (pipe_stall !== (k != wait_n)) begin bad++; $display("FAIL %s req_stall cyc%0d got=%b exp=%b", tag, k, pipe_stall, k != wait_n); end
    end
    @(negedge clk);
    mwb_valid = 1'b0; bus.dmem_ack = 1'b0;
    total++; if (bus.dmem_req !== 1'b0 || misalign !== 1'b0) begin bad++; $display("FAIL %s done req/mis got=%b%b exp=00", tag, bus.dmem_req, misalign); end
    total++; if (rf_we !== ewr) begin bad++; $display("FAIL %s rf_we got=%b exp=%b", tag, rf_we, ewr); end
    if (ewr) begin
      total++; if (rf_waddr !== rd || rf_wdata !== m_load(f3, addr[1:0], rdata)) begin bad++; $display("FAIL %s wb got=%0d/%h exp=%0d/%h", tag, rf_waddr, rf_wdata, rd, m_load(f3, addr[1:0], rdata)); end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; mwb_valid = 1'b0; mwb_ir = '0; mwb_alu_out = '0; mwb_rs2 = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    repeat (3) @(negedge clk);
    total++; if ({bus.dmem_req, bus.dmem_we, rf_we, misalign, err} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {bus.dmem_req, bus.dmem_we, rf_we, misalign, err}); end
    total++; if (bus.dmem_addr !== '0 || bus.dmem_be !== '0 || bus.dmem_wdata !== '0) begin bad++; $display("FAIL reset_bus got=%h/%h/%h exp=0", bus.dmem_addr, bus.dmem_be, bus.dmem_wdata); end
    total++; if (rf_waddr !== '0 || rf_wdata !== '0 || pipe_stall !== 1'b0) begin bad++; $display("FAIL reset_rf got=%h/%h/%b exp=0", rf_waddr, rf_wdata, pipe_stall); end
    rst = 1'b0;
  endtask

  task automatic test_alu_wb();
    logic [6:0] ops [12] = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                             7'b1100011, 7'b1110011, 7'b0001111, 7'b1111111, 7'b0101011, 7'b0010011};
    for (int i = 0; i < 40; i++) begin
      logic [6:0]  op  = (i == 0) ? 7'b0010011 : ops[$urandom_range(0, 11)];
      logic [4:0]  rd  = (i == 0) ? 5'd5 : 5'($urandom_range(0, 31));
      logic [31:0] val = (i == 0) ? 32'h42 : $urandom;
      bit          ewr = (op inside {7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111}) && rd != 0;
      @(negedge clk);
      mwb_valid = 1'b1; mwb_ir = mk_ir(op, 3'($urandom), rd); mwb_alu_out = val; mwb_rs2 = $urandom;
      #1;
      total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL alu_stall op=%b got=%b exp=0", op, pipe_stall); end
      @(negedge clk);
      mwb_valid = 1'b0;
      total++; if (rf_we !== ewr || bus.dmem_req !== 1'b0) begin bad++; $display("FAIL alu_we op=%b rd=%0d got=%b/%b exp=%b/0", op, rd, rf_we, bus.dmem_req, ewr); end
      if (ewr) begin
        total++; if (rf_waddr !== rd || rf_wdata !== val) begin bad++; $display("FAIL alu_wb got=%0d/%h exp=%0d/%h", rf_waddr, rf_wdata, rd, val); end
      end
    end
  endtask

  task automatic test_store_sw();
    int st_n, rq_n;
    mem_op(1'b1, 3'b010, 5'd0, 32'h100, 32'hDEADBEEF, 32'h0, 2, "sw", st_n, rq_n);
    total++; if (st_n !== 3 || rq_n !== 3) begin bad++; $display("FAIL sw_cycles stall/req got=%0d/%0d exp=3/3", st_n, rq_n); end
  endtask

  task automatic test_load_lb();
    int st_n, rq_n;
    mem_op(1'b0, 3'b000, 5'd7, 32'h203, 32'h0, 32'h80FF1234, 0, "lb", st_n, rq_n);
    total++; if (rf_wdata !== 32'hFFFF_FF80 || rq_n !== 1) begin bad++; $display("FAIL lb_value got=%h req=%0d exp=ffffff80 req=1", rf_wdata, rq_n); end
    mem_op(1'b0, 3'b100, 5'd7, 32'h203, 32'h0, 32'h80FF1234, 0, "lbu", st_n, rq_n);
    total++; if (rf_wdata !== 32'h0000_0080 || st_n !== 1) begin bad++; $display("FAIL lbu_value got=%h stall=%0d exp=00000080 stall=1", rf_wdata, st_n); end
  endtask

  task automatic test_misalign();
    logic [2:0] f3s [4] = '{3'b001, 3'b101, 3'b010, 3'b010};
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  f3 = (i == 0) ? 3'b010 : f3s[$urandom_range(0, 3)];
      bit          st = (i == 0) ? 1'b0 : ($urandom_range(0, 1) == 1 && f3 != 3'b101);
      logic [31:0] a  = (i == 0) ? 32'h102 : $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b1;
      else if (a[1:0] == 2'b00) a[1:0] = 2'($urandom_range(1, 3));
      @(negedge clk);
      mwb_valid = 1'b1; mwb_ir = mk_ir(st ? ST : LD, f3, 5'($urandom_range(1, 31))); mwb_alu_out = a; mwb_rs2 = $urandom;
      #1;
      total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL mis_stall a=%h got=%b exp=0", a, pipe_stall); end
      @(negedge clk);
      mwb_valid = 1'b0;
      total++; if (misalign !== 1'b1 || bus.dmem_req !== 1'b0 || rf_we !== 1'b0) begin bad++; $display("FAIL mis_pulse a=%h got mis/req/we=%b%b%b exp=100", a, misalign, bus.dmem_req, rf_we); end
      @(negedge clk);
      total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_width got=%b exp=0", misalign); end
    end
  endtask

  task automatic test_random_mem();
    logic [2:0] ldf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int st_n, rq_n;
    for (int i = 0; i < 40; i++) begin
      bit          st = $urandom_range(0, 1) == 1;
      logic [2:0]  f3 = st ? 3'($urandom_range(0, 2)) : ldf[$urandom_range(0, 4)];
      logic [31:0] a  = $urandom;
      int          w  = $urandom_range(0, 4);
      a = a & ~(32'(m_size(f3)) - 32'd1);
      mem_op(st, f3, 5'($urandom_range(0, 31)), a, $urandom, $urandom, w, "rnd", st_n, rq_n);
      total++; if (rq_n !== w + 1 || st_n !== w + 1) begin bad++; $display("FAIL rnd_cycles got=%0d/%0d exp=%0d", rq_n, st_n, w + 1); end
    end
  endtask

  task automatic test_ack_at_timeout();
    int st_n, rq_n;
    mem_op(1'b0, 3'b010, 5'd12, 32'h440, 32'h0, 32'h1234_5678, 15, "ack_to", st_n, rq_n);
    total++; if (err !== 1'b0 || rq_n !== 16) begin bad++; $display("FAIL ack_to_err got=%b req=%0d exp=0 req=16", err, rq_n); end
  endtask

  task automatic test_ack_idle();
    @(negedge clk);
    mwb_valid = 1'b0; bus.dmem_ack = 1'b1; bus.dmem_rdata = $urandom;
    #1;
    total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL idle_ack_stall got=%b exp=0", pipe_stall); end
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    total++; if (rf_we !== 1'b0 || bus.dmem_req !== 1'b0) begin bad++; $display("FAIL idle_ack_we got=%b/%b exp=0/0", rf_we, bus.dmem_req); end
  endtask

  task automatic test_timeout();
    int n = 0;
    @(negedge clk);
    mwb_valid = 1'b1; mwb_ir = mk_ir(LD, 3'b010, 5'd9); mwb_alu_out = 32'h300; bus.dmem_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.dmem_req !== 1'b1) break;
      n++;
      total++; if (pipe_stall !== (n != 16) || rf_we !== 1'b0) begin bad++; $display("FAIL to_stall cyc%0d got=%b/%b exp=%b/0", n, pipe_stall, rf_we, n != 16); end
    end
    total++; if (n !== 16) begin bad++; $display("FAIL to_req_cycles got=%0d exp=16", n); end
    mwb_valid = 1'b0;
    #1;
    total++; if (err !== 1'b1 || rf_we !== 1'b0 || pipe_stall !== 1'b0) begin bad++; $display("FAIL to_release err/we/stall got=%b%b%b exp=100", err, rf_we, pipe_stall); end
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mwb_valid = 1'b1; mwb_ir = mk_ir(LD, 3'b010, 5'd3); mwb_alu_out = 32'h40; bus.dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.dmem_req !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b exp=1", bus.dmem_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mwb_valid = 1'b0;
    #1;
    total++; if (bus.dmem_req !== 1'b0 || pipe_stall !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rmid_post req/stall/err got=%b%b%b exp=000", bus.dmem_req, pipe_stall, err); end
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rmid_late_ack got=%b exp=0", rf_we); end
    @(negedge clk);
    total++; if (rf_we !== 1'b0 || bus.dmem_req !== 1'b0) begin bad++; $display("FAIL rmid_no_wb got=%b/%b exp=0/0", rf_we, bus.dmem_req); end
    mwb_valid = 1'b1; mwb_ir = mk_ir(7'b0110111, 3'b000, 5'd1); mwb_alu_out = 32'hABCD_E000;
    @(negedge clk);
    mwb_valid = 1'b0;
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'hABCD_E000) begin bad++; $display("FAIL rmid_resume got=%b/%0d/%h exp=1/1/abcde000", rf_we, rf_waddr, rf_wdata); end
  endtask

  initial begin
    test_reset();
    test_alu_wb();
    test_store_sw();
    test_load_lb();
    test_misalign();
    test_random_mem();
    test_ack_at_timeout();
    test_ack_idle();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
